// File: rtl/gf180_ram_banked_as2650_pkg.sv
// ram_as2650_pkg: shared macro geometry, FSM states and bank decode for the banked AS2650 RAM
package ram_as2650_pkg;
  localparam int MACRO_ROWS = 512;
  localparam int MACRO_AW = 9;
  typedef enum logic {INIT, RUN} ram_state_t;
  function automatic logic [2:0] bank_of(input logic [11:0] addr);
    return addr[11:MACRO_AW];
  endfunction
endpackage

// File: rtl/gf180_ram_banked_as2650_bank.sv
// ram_bank_as2650: one bank of WIDTH_BYTES byte-wide macros sharing CEN, GWEN and A
module ram_bank_as2650
  import ram_as2650_pkg::*;
#(
  parameter int WIDTH_BYTES = 1
) (
  input  logic                     i_clk,
  input  logic                     i_cen,
  input  logic                     i_gwen,
  input  logic [MACRO_AW-1:0]      i_a,
  input  logic [8*WIDTH_BYTES-1:0] i_wen,
  input  logic [8*WIDTH_BYTES-1:0] i_d,
  output logic [8*WIDTH_BYTES-1:0] o_q
);
  for (genvar b = 0; b < WIDTH_BYTES; b++) begin : g_byte
    gf180mcu_fd_ip_sram__sram512x8m8wm1 u_sram (
      .CLK (i_clk),
      .CEN (i_cen),
      .GWEN(i_gwen),
      .WEN (i_wen[8*b+:8]),
      .A   (i_a),
      .D   (i_d[8*b+:8]),
      .Q   (o_q[8*b+:8])
    );
  end
endmodule

// File: rtl/gf180mcu_fd_ip_sram__sram512x8m8wm1.sv
// gf180mcu_fd_ip_sram__sram512x8m8wm1: behavioural model of the 512x8 SRAM macro (active-low CEN/GWEN/WEN)
module gf180mcu_fd_ip_sram__sram512x8m8wm1 (
  input  logic       CLK,
  input  logic       CEN,
  input  logic       GWEN,
  input  logic [7:0] WEN,
  input  logic [8:0] A,
  input  logic [7:0] D,
  output logic [7:0] Q
);
  logic [7:0] r_mem [512];
  always_ff @(posedge CLK) begin
    if (!CEN && !GWEN) r_mem[A] <= (r_mem[A] & WEN) | (D & ~WEN);
    if (!CEN && GWEN) Q <= r_mem[A];
  end
endmodule

// File: rtl/gf180_ram_banked_as2650.sv
// gf180_ram_banked_as2650: banked SRAM with valid/ready port and 2-cycle read response.
// Define RAM_ZERO_INIT_EN to zero-fill every row after reset before accepting requests.
module gf180_ram_banked_as2650
  import ram_as2650_pkg::*;
#(
  parameter int WIDTH_BYTES = 1,
  parameter int BANKS = 2,
  localparam int ADDR_W = MACRO_AW + $clog2(BANKS)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     REQ,
  input  logic                     WE,
  input  logic [ADDR_W-1:0]        ADDR,
  input  logic [8*WIDTH_BYTES-1:0] WDATA,
  input  logic [WIDTH_BYTES-1:0]   BE,
  output logic                     READY,
  output logic                     RVALID,
  output logic [8*WIDTH_BYTES-1:0] RDATA
);
  localparam int DW = 8 * WIDTH_BYTES;
  localparam int BW = BANKS > 1 ? $clog2(BANKS) : 1;
  logic                   r_ready, r_v1, r_v2, r_rvalid;
  logic [BW-1:0]          r_bank;
  logic [DW-1:0]          r_q, r_rdata;
  logic                   w_acc, w_init, w_gwen;
  logic [BW-1:0]          w_bank;
  logic [MACRO_AW-1:0]    w_a, w_cnt;
  logic [DW-1:0]          w_d, w_wen;
  logic [BANKS-1:0]       w_cen;
  logic [BANKS-1:0][DW-1:0] w_q;
  assign READY = r_ready;
  assign RVALID = r_rvalid;
  assign RDATA = r_rdata;
  assign w_acc = REQ & r_ready & ~RST;
  assign w_bank = BW'(bank_of(12'(ADDR)));
`ifdef RAM_ZERO_INIT_EN
  ram_state_t          r_state;
  logic [MACRO_AW-1:0] r_cnt;
  logic                w_last;
  assign w_init = (r_state == INIT) & ~RST;
  assign w_cnt = r_cnt;
  assign w_last = r_cnt == MACRO_AW'(MACRO_ROWS - 1);
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= INIT;
      r_cnt <= '0;
      r_ready <= 1'b0;
    end else begin
      r_ready <= (r_state == RUN) | w_last;
      if (r_state == INIT) r_cnt <= r_cnt + 1'b1;
      if (r_state == INIT && w_last) r_state <= RUN;
    end
  end
`else
  assign w_init = 1'b0;
  assign w_cnt = '0;
  always_ff @(posedge CLK) r_ready <= ~RST;
`endif
  // The clear sweep drives every macro with a zero write to the counter row.
  always_comb begin
    w_gwen = w_init ? 1'b0 : ~WE;
    w_a = w_init ? w_cnt : ADDR[MACRO_AW-1:0];
    w_d = w_init ? '0 : WDATA;
    w_wen = '1;
    for (int i = 0; i < WIDTH_BYTES; i++) w_wen[8*i+:8] = (w_init | BE[i]) ? 8'h00 : 8'hff;
  end
  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    assign w_cen[b] = ~(w_init | (w_acc & (w_bank == BW'(b))));
    ram_bank_as2650 #(.WIDTH_BYTES(WIDTH_BYTES)) u_bank (
      .i_clk (CLK),
      .i_cen (w_cen[b]),
      .i_gwen(w_gwen),
      .i_a   (w_a),
      .i_wen (w_wen),
      .i_d   (w_d),
      .o_q   (w_q[b])
    );
  end
  // Q is captured one cycle after the macro read so a following read to the same bank cannot clobber it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_v1 <= w_acc & ~WE;
      r_v2 <= r_v1;
      r_rvalid <= r_v2;
      if (w_acc & ~WE) r_bank <= w_bank;
      if (r_v1) r_q <= w_q[r_bank];
      if (r_v2) r_rdata <= r_q;
    end
  end
endmodule

// File: tb/tb_gf180_ram_banked_as2650.sv
// tb_gf180_ram_banked_as2650: random and directed checks against an array/queue reference model
module tb_gf180_ram_banked_as2650;
  localparam int WB = 2, NB = 2, AW = 10, DW = 16, WORDS = 1 << AW;
`ifdef RAM_ZERO_INIT_EN
  localparam int ZI = 1;
`else
  localparam int ZI = 0;
`endif
  localparam int RDY_AFTER = ZI ? 512 : 1;
  logic clk = 0, rst = 1, req = 0, we = 0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [WB-1:0] be = '0;
  logic ready, rvalid;
  logic [DW-1:0] rdata;
  int checks = 0, errors = 0, cyc = 0;
  gf180_ram_banked_as2650 #(.WIDTH_BYTES(WB), .BANKS(NB)) dut (
    .CLK(clk), .RST(rst), .REQ(req), .WE(we), .ADDR(addr), .WDATA(wdata), .BE(be),
    .READY(ready), .RVALID(rvalid), .RDATA(rdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  function automatic logic [DW-1:0] mask_of(input logic [WB-1:0] k);
    return {{8{k[1]}}, {8{k[0]}}};
  endfunction
  // Reference model: word array with per-byte known flags and a two-slot read delay line.
  logic [DW-1:0] mem [WORDS];
  logic [WB-1:0] kn [WORDS];
  logic started = 0, m_ready = 0, m_rvalid = 0;
  logic [DW-1:0] m_rdata = '0, m_mask = '1;
  logic pv [2];
  logic [DW-1:0] pd [2], pm [2];
  int since = 0;
  always @(posedge clk) begin
    logic acc;
    cyc++;
    if (rst) begin
      since = 0; m_ready = 0; m_rvalid = 0; m_rdata = '0; m_mask = '1;
      pv[0] = 0; pv[1] = 0;
      if (ZI == 1 || !started)
        for (int a = 0; a < WORDS; a++) begin
          mem[a] = '0;
          kn[a] = ZI == 1 ? '1 : '0;
        end
      started = 1;
    end else begin
      acc = req && m_ready;
      m_rvalid = pv[1];
      if (pv[1]) begin m_rdata = pd[1]; m_mask = pm[1]; end
      pv[1] = pv[0]; pd[1] = pd[0]; pm[1] = pm[0];
      pv[0] = acc && !we;
      if (pv[0]) begin pd[0] = mem[addr]; pm[0] = mask_of(kn[addr]); end
      if (acc && we)
        for (int i = 0; i < WB; i++)
          if (be[i]) begin mem[addr][8*i+:8] = wdata[8*i+:8]; kn[addr][i] = 1'b1; end
      since++;
      m_ready = since >= RDY_AFTER;
    end
  end
  logic [DW-1:0] got [$];
  int gotc [$];
  always @(negedge clk) begin
    chk("ready", 32'(ready), 32'(m_ready));
    chk("rvalid", 32'(rvalid), 32'(m_rvalid));
    chk("rdata", 32'(rdata & m_mask), 32'(m_rdata & m_mask));
    if (rst && req) chk("cen_in_rst", 32'(dut.w_cen), 32'(2'b11));
    if (rvalid) begin got.push_back(rdata); gotc.push_back(cyc); end
  end
  task automatic op(input logic w, input int a, input logic [DW-1:0] d, input logic [WB-1:0] b);
    @(posedge clk); #1;
    req = 1; we = w; addr = AW'(a); wdata = d; be = b;
  endtask
  task automatic idle(input int n);
    @(posedge clk); #1 req = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_ready(input string n);
    int k = 0;
    while (k < 2000) begin
      @(negedge clk);
      if (ready) break;
      k++;
    end
    chk(n, 32'(k), 32'(RDY_AFTER));
  endtask
  initial begin
    int acc_c;
    rst = 1; req = 1; we = 0; addr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0; req = 0;
    wait_ready("init_len");
    if (ZI == 1) begin
      got.delete(); gotc.delete();
      op(0, 'h3FF, 0, 0); acc_c = cyc + 1;
      idle(4);
      chk("zi_count", 32'(got.size()), 1);
      if (got.size() == 1) begin
        chk("zi_data", 32'(got[0]), 0);
        chk("zi_lat", 32'(gotc[0] - acc_c), 2);
      end
    end
    op(1, 'h005, 16'hA55A, 2'b11);
    op(1, 'h205, 16'h1234, 2'b11);
    got.delete(); gotc.delete();
    op(0, 'h005, 0, 0); acc_c = cyc + 1;
    op(0, 'h205, 0, 0);
    op(0, 'h005, 0, 0);
    idle(5);
    chk("b2b_count", 32'(got.size()), 3);
    if (got.size() == 3) begin
      chk("b2b_0", 32'(got[0]), 32'h A55A);
      chk("b2b_1", 32'(got[1]), 32'h1234);
      chk("b2b_2", 32'(got[2]), 32'hA55A);
      chk("b2b_lat", 32'(gotc[0] - acc_c), 2);
      chk("b2b_gap", 32'(gotc[2] - gotc[0]), 2);
    end
    got.delete(); gotc.delete();
    op(1, 'h010, 16'hFFFF, 2'b11);
    op(1, 'h010, 16'h0000, 2'b01);
    op(0, 'h010, 0, 0);
    op(1, 'h010, 16'hBEEF, 2'b00);
    op(0, 'h010, 0, 0);
    idle(5);
    chk("be_count", 32'(got.size()), 2);
    if (got.size() == 2) begin
      chk("be_low", 32'(got[0]), 32'hFF00);
      chk("be_zero", 32'(got[1]), 32'hFF00);
    end
    got.delete(); gotc.delete();
    op(0, 'h005, 0, 0);
    @(posedge clk); #1 req = 0; rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_rdata", 32'(rdata), 0);
    wait_ready("reinit_len");
    chk("rst_no_rvalid", 32'(got.size()), 0);
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      req = $urandom_range(3, 0) != 0;
      we = $urandom_range(1, 0) == 1;
      addr = AW'($urandom_range(7, 0) + 512 * $urandom_range(1, 0));
      wdata = DW'($urandom);
      be = WB'($urandom);
    end
    idle(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
